// File: rtl/e_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_if
//  Description : Bundle between the E-stage pipeline and the multiply/divide
//                unit. The pipeline (master) supplies the operation, its
//                launch pulse and the forwarded operands. The MDU (slave)
//                returns busy, the architectural HI/LO registers and the
//                mfhi/mflo read value.
//  Signals     : start   1   launch pulse for a multi-cycle op
//                MDUOp   4   operation code
//                A, B    32  rs / rt operands (forwarded)
//                busy    1   multi-cycle op in flight
//                HI, LO  32  architectural HI / LO
//                MDUOut  32  HI for mfhi, LO for mflo, otherwise 0
//  Revision    : 1.0 - initial release
// ============================================================================
interface e_mdu_if;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output start, MDUOp, A, B,
        input  busy, HI, LO, MDUOut
    );

    modport slave (
        input  start, MDUOp, A, B,
        output busy, HI, LO, MDUOut
    );
endinterface
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu
//  Description : Multi-cycle multiply/divide unit for the E stage. Holds the
//                HI/LO registers, runs mult/multu/div/divu over a fixed
//                number of cycles and executes mthi/mtlo/mfhi/mflo.
//                The result is computed at the launch edge and parked in
//                pending registers; it is written to HI/LO when the busy
//                countdown expires, so HI/LO only move at commit, at
//                mthi/mtlo or at reset.
//  Ports       : clk      in   rising-edge system clock
//                reset_n  in   asynchronous active-low reset
//                mdu      slave modport of e_mdu_if (start, MDUOp, A, B in;
//                         busy, HI, LO, MDUOut out)
//  Parameters  : MULT_CYCLES  busy duration of multiply/accumulate ops
//                DIV_CYCLES   busy duration of divide ops
//  Macros      : MDU_MADD_EN  enables madd/maddu/msub/msubu (MDUOp 9..12)
//  Revision    : 1.0 - initial release
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset_n,
    e_mdu_if.slave    mdu
);

    localparam int C_MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

    localparam logic [3:0] C_OP_MULT  = 4'd1;
    localparam logic [3:0] C_OP_MULTU = 4'd2;
    localparam logic [3:0] C_OP_DIV   = 4'd3;
    localparam logic [3:0] C_OP_DIVU  = 4'd4;
    localparam logic [3:0] C_OP_MTHI  = 4'd5;
    localparam logic [3:0] C_OP_MTLO  = 4'd6;
    localparam logic [3:0] C_OP_MFHI  = 4'd7;
    localparam logic [3:0] C_OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] C_OP_MADD  = 4'd9;
    localparam logic [3:0] C_OP_MADDU = 4'd10;
    localparam logic [3:0] C_OP_MSUB  = 4'd11;
    localparam logic [3:0] C_OP_MSUBU = 4'd12;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               busy_q,    busy_d;
    logic [C_CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]        temp_hi_q, temp_hi_d;
    logic [31:0]        temp_lo_q, temp_lo_d;
    logic               skip_q,    skip_d;    // divide by zero: suppress commit
    logic [31:0]        hi_q,      hi_d;
    logic [31:0]        lo_q,      lo_d;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic w_is_mul;
    logic w_is_div;
    logic w_is_acc;
    logic w_launch;

    assign w_is_mul = (mdu.MDUOp == C_OP_MULT) || (mdu.MDUOp == C_OP_MULTU);
    assign w_is_div = (mdu.MDUOp == C_OP_DIV)  || (mdu.MDUOp == C_OP_DIVU);
`ifdef MDU_MADD_EN
    assign w_is_acc = (mdu.MDUOp >= C_OP_MADD) && (mdu.MDUOp <= C_OP_MSUBU);
`else
    assign w_is_acc = 1'b0;
`endif
    assign w_launch = mdu.start && !busy_q && (w_is_mul || w_is_div || w_is_acc);

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_divisor_s;
    logic [31:0] w_divisor_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    assign w_prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
    assign w_prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

    // The divider never sees a zero divisor (result is discarded anyway),
    // and -2^31 / -1 is steered to a divide by 1, which yields the wrapped
    // quotient 0x80000000 with remainder 0 without signed overflow.
    assign w_div_zero  = (mdu.B == 32'd0);
    assign w_div_ovf   = (mdu.A == 32'h8000_0000) && (mdu.B == 32'hFFFF_FFFF);
    assign w_divisor_s = (w_div_zero || w_div_ovf) ? 32'd1 : mdu.B;
    assign w_divisor_u = w_div_zero ? 32'd1 : mdu.B;

    assign w_quot_s = $signed(mdu.A) / $signed(w_divisor_s);
    assign w_rem_s  = $signed(mdu.A) % $signed(w_divisor_s);
    assign w_quot_u = mdu.A / w_divisor_u;
    assign w_rem_u  = mdu.A % w_divisor_u;

    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (mdu.MDUOp)
            C_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            C_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            C_OP_DIV:   {w_res_hi, w_res_lo} = {w_rem_s, w_quot_s};
            C_OP_DIVU:  {w_res_hi, w_res_lo} = {w_rem_u, w_quot_u};
`ifdef MDU_MADD_EN
            // Accumulation base is HI/LO as held at the launch edge.
            C_OP_MADD:  {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod_s;
            C_OP_MADDU: {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod_u;
            C_OP_MSUB:  {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod_s;
            C_OP_MSUBU: {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod_u;
`endif
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        skip_d    = skip_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (busy_q) begin
            // Anything launched or moved while busy is ignored.
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                if (!skip_q) begin
                    hi_d = temp_hi_q;
                    lo_d = temp_lo_q;
                end
            end else begin
                cnt_d = cnt_q - C_CNT_ONE;
            end
        end else if (w_launch) begin
            busy_d    = 1'b1;
            cnt_d     = w_is_div ? C_DIV_LOAD : C_MULT_LOAD;
            temp_hi_d = w_res_hi;
            temp_lo_d = w_res_lo;
            skip_d    = w_is_div && w_div_zero;
        end else if (mdu.MDUOp == C_OP_MTHI) begin
            hi_d = mdu.A;
        end else if (mdu.MDUOp == C_OP_MTLO) begin
            lo_d = mdu.A;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
            skip_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            skip_q    <= skip_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mdu.busy   = busy_q;
    assign mdu.HI     = hi_q;
    assign mdu.LO     = lo_q;
    assign mdu.MDUOut = (mdu.MDUOp == C_OP_MFHI) ? hi_q :
                        (mdu.MDUOp == C_OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_mdu
//  Description : Self-checking bench for e_mdu. Expected HI/LO pairs are
//                pushed to a scoreboard queue at launch and popped when busy
//                falls. Also covers mthi/mtlo/mfhi/mflo, divide by zero,
//                operations issued while busy, asynchronous reset and the
//                optional multiply-accumulate ops (MDU_MADD_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e_mdu;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    e_mdu_if mif ();

    e_mdu #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu     (mif)
    );

    exp_t sb_q[$];
    exp_t m;                 // bench copy of HI/LO
    int   n_vec = 0;
    int   n_err = 0;
    bit   allow_busy_start = 1'b0;

    // The hazard unit never issues start while busy; only the deliberate
    // scenario below may do so.
    always @(posedge clk) begin
        if (reset_n && !allow_busy_start)
            assert (!(mif.start && mif.busy))
                else $error("hazard violation: start asserted while busy");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input exp_t cur);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     acc = {cur.hi, cur.lo};
        logic [63:0]     r64;
        exp_t            r = cur;
        case (op)
            4'd1: r = exp_t'(sa * sb);
            4'd2: r = exp_t'(ua * ub);
            4'd3: if (b != 0) begin
                      r64 = sa / sb;   r.lo = r64[31:0];
                      r64 = sa % sb;   r.hi = r64[31:0];
                  end
            4'd4: if (b != 0) begin
                      r64 = ua / ub;   r.lo = r64[31:0];
                      r64 = ua % ub;   r.hi = r64[31:0];
                  end
            4'd9:  r = exp_t'(acc + 64'(sa * sb));
            4'd10: r = exp_t'(acc + 64'(ua * ub));
            4'd11: r = exp_t'(acc - 64'(sa * sb));
            4'd12: r = exp_t'(acc - 64'(ua * ub));
            default: r = cur;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.start = 1'b1;
        mif.MDUOp = op;
        mif.A     = a;
        mif.B     = b;
        @(negedge clk);
        mif.start = 1'b0;
        mif.MDUOp = 4'd0;
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        mif.MDUOp = op;
        mif.A     = a;
        @(negedge clk);
        mif.MDUOp = 4'd0;
        if (op == 4'd5) m.hi = a;
        else            m.lo = a;
    endtask

    // Counts negedges at which busy is high, bounded.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (mif.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        mif.start = 1'b0; mif.MDUOp = 4'd7; mif.A = 32'd0; mif.B = 32'd0;
        #1;
        n_vec++;
        if (mif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", mif.busy); end
        n_vec++;
        if ({mif.HI, mif.LO} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h expected 0", {mif.HI, mif.LO}); end
        n_vec++;
        if (mif.MDUOut !== 32'd0) begin n_err++; $display("FAIL reset_mduout: got %h expected 0", mif.MDUOut); end
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        mif.MDUOp = 4'd0;
        m         = '0;
    endtask

    task automatic test_mult();
        int   cyc;
        exp_t e;
        launch(4'd1, 32'hFFFF_FFFD, 32'd5);
        sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1});
        wait_idle(cyc);
        n_vec++;
        if (cyc !== MULT_CYCLES) begin n_err++; $display("FAIL mult_busy_cycles: got %0d expected %0d", cyc, MULT_CYCLES); end
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL mult_result: got %h expected %h", {mif.HI, mif.LO}, e); end
        m = e;
    endtask

    task automatic test_div();
        int   cyc;
        exp_t e;
        launch(4'd4, 32'd17, 32'd5);
        sb_q.push_back('{hi: 32'd2, lo: 32'd3});
        wait_idle(cyc);
        n_vec++;
        if (cyc !== DIV_CYCLES) begin n_err++; $display("FAIL divu_busy_cycles: got %0d expected %0d", cyc, DIV_CYCLES); end
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL divu_result: got %h expected %h", {mif.HI, mif.LO}, e); end

        launch(4'd3, 32'hFFFF_FFF9, 32'd2);
        sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        wait_idle(cyc);
        n_vec++;
        if (cyc !== DIV_CYCLES) begin n_err++; $display("FAIL div_busy_cycles: got %0d expected %0d", cyc, DIV_CYCLES); end
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL div_result: got %h expected %h", {mif.HI, mif.LO}, e); end
        m = e;
    endtask

    task automatic test_div_zero();
        int   cyc;
        exp_t e;
        move(4'd5, 32'h0000_1234);
        move(4'd6, 32'h0000_5678);
        n_vec++;
        if ({mif.HI, mif.LO} !== {32'h1234, 32'h5678}) begin
            n_err++; $display("FAIL mthi_mtlo: got %h expected %h", {mif.HI, mif.LO}, {32'h1234, 32'h5678});
        end
        launch(4'd3, 32'd9, 32'd0);
        sb_q.push_back('{hi: 32'h1234, lo: 32'h5678});
        wait_idle(cyc);
        n_vec++;
        if (cyc !== DIV_CYCLES) begin n_err++; $display("FAIL divzero_busy_cycles: got %0d expected %0d", cyc, DIV_CYCLES); end
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL divzero_hilo: got %h expected %h", {mif.HI, mif.LO}, e); end
        m = e;
    endtask

    task automatic test_move();
        @(negedge clk);
        mif.MDUOp = 4'd5;
        mif.A     = 32'hAAAA_0000;
        #1;
        n_vec++;
        if (mif.MDUOut !== 32'd0) begin n_err++; $display("FAIL mduout_nonread: got %h expected 0", mif.MDUOut); end
        @(negedge clk);
        m.hi      = 32'hAAAA_0000;
        mif.MDUOp = 4'd8;
        #1;
        n_vec++;
        if (mif.MDUOut !== m.lo) begin n_err++; $display("FAIL mflo: got %h expected %h", mif.MDUOut, m.lo); end
        @(negedge clk);
        mif.MDUOp = 4'd7;
        #1;
        n_vec++;
        if (mif.MDUOut !== 32'hAAAA_0000) begin n_err++; $display("FAIL mfhi: got %h expected aaaa0000", mif.MDUOut); end
        @(negedge clk);
        mif.MDUOp = 4'd0;
    endtask

    task automatic test_busy_ignore();
        int   cyc;
        exp_t e;
        launch(4'd1, 32'd7, 32'd6);
        sb_q.push_back(model(4'd1, 32'd7, 32'd6, m));
        n_vec++;
        if (mif.busy !== 1'b1) begin n_err++; $display("FAIL busy_after_launch: got %b expected 1", mif.busy); end
        mif.MDUOp = 4'd6;                      // mtlo while busy
        mif.A     = 32'hDEAD_BEEF;
        @(negedge clk);
        mif.MDUOp = 4'd0;
        n_vec++;
        if (mif.LO !== m.lo) begin n_err++; $display("FAIL mtlo_while_busy: got %h expected %h", mif.LO, m.lo); end
        allow_busy_start = 1'b1;               // start while busy
        mif.start = 1'b1;
        mif.MDUOp = 4'd3;
        mif.A     = 32'd100;
        mif.B     = 32'd3;
        @(negedge clk);
        mif.start = 1'b0;
        allow_busy_start = 1'b0;
        mif.MDUOp = 4'd7;                      // mfhi while busy -> old HI
        #1;
        n_vec++;
        if (mif.MDUOut !== m.hi) begin n_err++; $display("FAIL mfhi_while_busy: got %h expected %h", mif.MDUOut, m.hi); end
        wait_idle(cyc);
        mif.MDUOp = 4'd0;
        n_vec++;
        if (cyc + 2 !== MULT_CYCLES) begin n_err++; $display("FAIL busy_ignore_cycles: got %0d expected %0d", cyc + 2, MULT_CYCLES); end
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL busy_ignore_result: got %h expected %h", {mif.HI, mif.LO}, e); end
        m = e;
    endtask

    task automatic test_random();
        int          cyc;
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i == 0) begin op = 4'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 1) begin op = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            launch(op, a, b);
            sb_q.push_back(model(op, a, b, m));
            wait_idle(cyc);
            n_vec++;
            if (cyc !== ((op >= 4'd3) ? DIV_CYCLES : MULT_CYCLES)) begin
                n_err++; $display("FAIL rand_cycles op=%0d: got %0d", op, cyc);
            end
            e = sb_q.pop_front();
            n_vec++;
            if ({mif.HI, mif.LO} !== e) begin
                n_err++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", op, a, b, {mif.HI, mif.LO}, e);
            end
            m = e;
        end
    endtask

    task automatic test_madd();
        int   cyc;
        exp_t e;
        move(4'd5, 32'd0);
        move(4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        launch(4'd10, 32'd1, 32'd1);
        sb_q.push_back('{hi: 32'd1, lo: 32'd0});
        wait_idle(cyc);
        n_vec++;
        if (cyc !== MULT_CYCLES) begin n_err++; $display("FAIL maddu_cycles: got %0d expected %0d", cyc, MULT_CYCLES); end
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL maddu_result: got %h expected %h", {mif.HI, mif.LO}, e); end
        m = e;
        launch(4'd11, 32'd2, 32'd3);
        sb_q.push_back('{hi: 32'd0, lo: 32'hFFFF_FFFA});
        wait_idle(cyc);
        e = sb_q.pop_front();
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL msub_result: got %h expected %h", {mif.HI, mif.LO}, e); end
        m = e;
`else
        launch(4'd10, 32'd1, 32'd1);
        n_vec++;
        if (mif.busy !== 1'b0) begin n_err++; $display("FAIL maddu_disabled_busy: got %b expected 0", mif.busy); end
        wait_idle(cyc);
        repeat (MULT_CYCLES + 1) @(negedge clk);
        e = m;
        n_vec++;
        if ({mif.HI, mif.LO} !== e) begin n_err++; $display("FAIL maddu_disabled_hilo: got %h expected %h", {mif.HI, mif.LO}, e); end
`endif
    endtask

    task automatic test_async_reset();
        int cyc;
        move(4'd5, 32'h5555_1111);
        launch(4'd1, 32'd3, 32'd4);            // now in busy cycle 1
        repeat (2) @(negedge clk);             // busy cycle 3
        #2;
        reset_n = 1'b0;
        #1;                                    // still well before the next edge
        n_vec++;
        if (mif.busy !== 1'b0) begin n_err++; $display("FAIL async_reset_busy: got %b expected 0", mif.busy); end
        n_vec++;
        if ({mif.HI, mif.LO} !== 64'd0) begin n_err++; $display("FAIL async_reset_hilo: got %h expected 0", {mif.HI, mif.LO}); end
        m = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (MULT_CYCLES + 3) @(negedge clk);
        wait_idle(cyc);
        n_vec++;
        if (cyc !== 0) begin n_err++; $display("FAIL post_reset_busy: got %0d busy cycles expected 0", cyc); end
        n_vec++;
        if ({mif.HI, mif.LO} !== 64'd0) begin n_err++; $display("FAIL post_reset_no_commit: got %h expected 0", {mif.HI, mif.LO}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_move();
        test_busy_ignore();
        test_random();
        test_madd();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
